// File: rtl/pwm_led_core.sv
// Multi-channel LED PWM core behind a small register slot. A shared prescaler
// and duty counter drive per-channel compares; duty updates land only at period boundaries.
module pwm_led_core #(
  parameter int W = 8,
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic [W-1:0] pwm_out
);

  logic [31:0]  dvsr;
  logic [31:0]  q;
  logic [W-1:0] enable;
  logic [R-1:0] d;
  logic [R:0]   duty_shadow [W];
  logic [R:0]   duty_active [W];
  logic         wr_en;
  logic         tick;
  logic         boundary;
  logic         read_unused;

  // Reads have no side effects, so the strobe is not needed.
  assign read_unused = read;

  assign wr_en    = cs && write;
  assign tick     = (q >= dvsr);
  assign boundary = tick && (d == {R{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvsr   <= '0;
      enable <= '0;
    end else if (wr_en) begin
      if (addr == 5'd0) dvsr <= wr_data;
      if (addr == 5'd1) enable <= wr_data[W-1:0];
    end
  end

  // The active copy samples the pre-edge shadow, so a shadow write landing on
  // a boundary edge waits for the following boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < W; i++) begin
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (wr_en && (addr == 5'(16 + i))) duty_shadow[i] <= wr_data[R:0];
        if (boundary) duty_active[i] <= duty_shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
      d <= '0;
    end else begin
      if (tick) begin
        q <= '0;
        d <= d + R'(1);
      end else begin
        q <= q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        pwm_out[i] <= enable[i] && ({1'b0, d} < duty_active[i]);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0: rd_data = dvsr;
      5'd1: rd_data = 32'(enable);
      5'd2: rd_data = 32'(d);
      default: begin
        for (int i = 0; i < W; i++) begin
          if (addr == 5'(16 + i)) rd_data = 32'(duty_shadow[i]);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_led_core.sv
// Directed bench for pwm_led_core (W=8, R=8): register map, prescaler timing,
// shadowed duty updates, enable gating and asynchronous reset.
module tb_pwm_led_core;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  pwm_out;

  int checks;
  int failures;
  int cyc;
  int e0;
  int d0;
  int bad;

  pwm_led_core #(.W(8), .R(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .pwm_out (pwm_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edges since reset release; with DVSR=0 the duty counter equals cyc mod 256.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] dt);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = dt;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic chk_rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    check(rd_data, exp, tag);
  endtask

  // Call right after a boundary edge: runs one 256-edge period with channel 0
  // enabled alone and the given active duty, optionally writing on edge wr_off.
  task automatic check_period(input int duty, input int wr_off, input logic [4:0] wa,
                              input logic [31:0] wd, input string tag);
    int   hits;
    logic exp_bit;
    hits = 0;
    for (int j = 1; j <= 256; j++) begin
      if (j == wr_off) begin
        cs = 1'b1; write = 1'b1; addr = wa; wr_data = wd;
      end
      @(posedge clk);
      #1;
      cs = 1'b0; write = 1'b0;
      exp_bit = ((j - 1) < duty);
      hits += int'(pwm_out[0]);
      check(32'(pwm_out), 32'(exp_bit), tag);
    end
    check(32'(hits), 32'((duty > 256) ? 256 : duty), {tag, "_hightime"});
  endtask

  initial begin
    checks = 0; failures = 0; bad = 0;
    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;

    #12;
    check(32'(pwm_out), 32'h0, "rst_pwm");
    chk_rd(5'd0, 32'h0, "rst_dvsr");
    chk_rd(5'd1, 32'h0, "rst_enable");
    chk_rd(5'd2, 32'h0, "rst_d");
    chk_rd(5'd16, 32'h0, "rst_duty0");

    // Release reset with an ENABLE write landing on the very first edge.
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'h1;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
    chk_rd(5'd1, 32'h1, "first_edge_enable");
    chk_rd(5'd2, 32'h1, "first_edge_d");

    wr(5'd16, 32'd64);                       // edge 2
    chk_rd(5'd16, 32'd64, "shadow_rd");
    check(32'(pwm_out), 32'h0, "pre_boundary_pwm");
    cyc_wait(254);                           // edge 256: first boundary
    check(32'(pwm_out), 32'h0, "boundary_edge_pwm");
    chk_rd(5'd2, 32'h0, "d_wrapped");

    check_period(64, -1, 5'd0, 32'd0, "duty64");
    check_period(64, 100, 5'd16, 32'd200, "duty64_midwrite");
    check_period(200, -1, 5'd0, 32'd0, "duty200");
    check_period(200, 10, 5'd16, 32'd0, "duty200_wr0");
    check_period(0, 20, 5'd16, 32'd256, "duty0");
    check_period(256, 256, 5'd16, 32'd32, "duty256_bndwrite");
    check_period(256, -1, 5'd0, 32'd0, "duty256_held");
    check_period(32, -1, 5'd0, 32'd0, "duty32");

    // Clearing ENABLE: the write edge still uses the old enable.
    wr(5'd1, 32'h0);
    check(32'(pwm_out), 32'h01, "en_clr_same_edge");
    cyc_wait(1);
    check(32'(pwm_out), 32'h00, "en_clr_next_edge");
    chk_rd(5'd2, 32'(cyc % 256), "en_clr_d_runs");
    for (int k = 0; k < 40; k++) begin
      cyc_wait(1);
      if (pwm_out !== 8'h00) bad++;
    end
    check(32'(bad), 32'h0, "en_clr_stays_low");

    chk_rd(5'd5, 32'h0, "rd_addr5");
    chk_rd(5'd31, 32'h0, "rd_addr31");
    wr(5'd5, 32'hFFFF_FFFF);
    wr(5'd31, 32'h0000_01FF);
    chk_rd(5'd0, 32'h0, "wr5_dvsr");
    chk_rd(5'd1, 32'h0, "wr5_enable");
    chk_rd(5'd16, 32'd32, "wr5_duty0");
    chk_rd(5'd31, 32'h0, "wr31_ignored");
    chk_rd(5'd2, 32'(cyc % 256), "wr5_d_aligned");

    wr(5'd1, 32'hFF);
    wr(5'd23, 32'd128);
    wr(5'd16, 32'd256);
    chk_rd(5'd1, 32'hFF, "enable_ff");
    chk_rd(5'd23, 32'd128, "duty7_rd");
    chk_rd(5'd16, 32'd256, "duty0_256_rd");

    // Prescaler: DVSR=3 gives a tick every 4 edges.
    wr(5'd0, 32'd3);
    e0 = cyc;
    d0 = e0 % 256;
    chk_rd(5'd0, 32'd3, "dvsr3_rd");
    chk_rd(5'd2, 32'(d0), "dvsr3_start");
    cyc_wait(3);
    chk_rd(5'd2, 32'(d0), "dvsr3_hold");
    cyc_wait(1);
    chk_rd(5'd2, 32'((d0 + 1) % 256), "dvsr3_tick");
    cyc_wait(1019);
    chk_rd(5'd2, 32'((d0 + 255) % 256), "dvsr3_almost_period");
    cyc_wait(1);
    chk_rd(5'd2, 32'(d0), "dvsr3_period_1024");

    // q is 0 now; after two edges it is 2, and the write edge moves it to 3.
    cyc_wait(2);
    wr(5'd0, 32'd1);
    chk_rd(5'd0, 32'd1, "dvsr1_rd");
    chk_rd(5'd2, 32'(d0), "dvsr1_no_tick_yet");
    cyc_wait(1);
    chk_rd(5'd2, 32'((d0 + 1) % 256), "dvsr1_immediate_tick");
    cyc_wait(1);
    chk_rd(5'd2, 32'((d0 + 1) % 256), "dvsr1_gap");
    cyc_wait(1);
    chk_rd(5'd2, 32'((d0 + 2) % 256), "dvsr1_every2");
    cyc_wait(20);
    chk_rd(5'd2, 32'((d0 + 12) % 256), "dvsr1_run");
    check(32'(pwm_out[0]), 32'h1, "duty256_const_high");

    // Asynchronous reset mid-period.
    #2;
    reset = 1'b0;
    #1;
    check(32'(pwm_out), 32'h0, "async_rst_pwm");
    chk_rd(5'd0, 32'h0, "async_rst_dvsr");
    chk_rd(5'd1, 32'h0, "async_rst_enable");
    chk_rd(5'd2, 32'h0, "async_rst_d");
    chk_rd(5'd16, 32'h0, "async_rst_duty0");
    chk_rd(5'd23, 32'h0, "async_rst_duty7");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc_wait(1);
    chk_rd(5'd2, 32'h1, "post_rst_d");
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      cyc_wait(1);
      if (pwm_out !== 8'h00) bad++;
    end
    check(32'(bad), 32'h0, "post_rst_quiet");
    chk_rd(5'd2, 32'(cyc % 256), "post_rst_d_runs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_led_core.md
PWM_LED_CORE -- requirements
Module: pwm_led_core

Interface
REQ-001 Parameter W, default 8: number of PWM channels (1..16).
REQ-002 Parameter R, default 8: duty resolution in bits; one PWM period = 2^R ticks.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cs  input  1  slot chip select.
REQ-006 read  input  1  slot read strobe.
REQ-007 write  input  1  slot write strobe.
REQ-008 addr  input  5  register index within the slot.
REQ-009 wr_data  input  32  slot write data.
REQ-010 rd_data  output  32  slot read data, combinational from addr.
REQ-011 pwm_out  output  W  registered PWM outputs, one per channel, to the LED pins.

Function
REQ-012 Write strobe: wr_en = cs && write, sampled on the rising clk edge; read has no side effects.
REQ-013 Register map: addr 0 = DVSR (32 bits); addr 1 = ENABLE (W bits, wr_data[W-1:0]); addr 16+i, i<W = DUTY_SHADOW[i] (R+1 bits, wr_data[R:0]); writes to other addresses are ignored.
REQ-014 Prescaler: 32-bit counter q; if q >= DVSR then q <= 0 and tick = 1, else q <= q+1 and tick = 0.
REQ-015 A DVSR write takes effect the next cycle; if q already exceeds the new DVSR, the next cycle produces a tick and q restarts at 0.
REQ-016 DVSR = 0 produces a tick every clock cycle.
REQ-017 Duty counter d (R bits) increments by 1 on each tick and wraps from 2^R-1 to 0.
REQ-018 Period boundary = tick asserted while d = 2^R-1.
REQ-019 At each period boundary, every DUTY_ACTIVE[i] <= DUTY_SHADOW[i] (glitch-free update).
REQ-020 Outside period boundaries, DUTY_ACTIVE does not change.
REQ-021 A shadow write in the same cycle as a boundary is NOT taken into that boundary; it is loaded at the next boundary.
REQ-022 pwm_out[i] <= ENABLE[i] && ({1'b0,d} < DUTY_ACTIVE[i]), registered: one clk latency after d changes.
REQ-023 DUTY_ACTIVE[i] = 0 gives pwm_out[i] constant 0.
REQ-024 DUTY_ACTIVE[i] >= 2^R gives pwm_out[i] constant 1 while enabled.
REQ-025 Clearing ENABLE[i] forces pwm_out[i] low on the next edge; d and q continue running.
REQ-026 Read map: addr 0 returns DVSR; addr 1 returns ENABLE zero-extended; addr 2 returns d zero-extended.
REQ-027 Read map: addr 16+i returns DUTY_SHADOW[i] zero-extended; all other addresses return 0.
REQ-028 rd_data is independent of cs and read; the bus mux qualifies it.

Reset
REQ-029 While reset = 0 (asynchronous), the following clear to 0: q, d, DVSR, ENABLE, all DUTY_SHADOW, all DUTY_ACTIVE, pwm_out.
REQ-030 Reset asserted mid-period abandons the period; after release, counting restarts from q = 0 and d = 0 with all outputs low.
REQ-031 The first edge after reset release performs normal operation, including any slot write.

Verification
REQ-032 Defaults W=8, R=8: write DVSR=0, ENABLE=0x01, DUTY[16]=64, wait one boundary -> pwm_out[0] high 64 of every 256 cycles, one cycle after d wraps.
REQ-033 DUTY[16]=0 then 256 after successive boundaries -> pwm_out[0] constant 0, then constant 1 across a full period.
REQ-034 Write DUTY[16]=200 mid-period with active value 64 -> current period keeps a 64-cycle high time; the next period has a 200-cycle high time; no runt pulses.
REQ-035 DVSR=3 -> d increments every 4 clk; period = 1024 clk. Then write DVSR=1 while q=3 -> tick on the next cycle, after which ticks occur every 2 clk.
REQ-036 Assert reset mid-period with ENABLE=0xFF -> pwm_out=0 immediately; readback of addr 0, 1, 2 and 16 returns 0; no output toggles until registers are rewritten.
REQ-037 Read addr 5 and addr 31 -> 0. Write addr 5 -> no register changes.
